// File: rtl/sd_block_writer_if.sv
// Handshake bundle for the SD block writer: start/status, FIFO read side and SPI pins.
// The writer drives the SPI pins only while busy; the top-level mux picks them up from here.
interface sd_block_writer_if;
  logic        start;
  logic [31:0] address;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        miso;
  logic        mosi;
  logic        sclk;
  logic        cs;
  logic        busy;
  logic        done;
  logic [2:0]  error;

  modport slave (
    input  start, address, fifo_data, fifo_empty, miso,
    output fifo_pop, mosi, sclk, cs, busy, done, error
  );

  modport master (
    output start, address, fifo_data, fifo_empty, miso,
    input  fifo_pop, mosi, sclk, cs, busy, done, error
  );
endinterface

// File: rtl/sd_block_writer.sv
// SPI-mode SD single-block writer (CMD24): sends the command, streams one block from a
// first-word-fall-through FIFO, checks the data response and waits out the card busy phase.
//
// state      | meaning
// S_IDLE     | waiting for start, SPI pins parked
// S_CMD      | sending 0x58, four address bytes, 0xFF
// S_R1       | polling for the R1 response
// S_GAP      | one 0xFF byte before the token
// S_TOKEN    | sending start token 0xFE
// S_DATA     | streaming BLOCK_LEN bytes from the FIFO, stalls when empty
// S_CRC      | two dummy CRC bytes
// S_RESP     | polling for the data response token
// S_BUSY     | polling while the card holds MISO low
// S_END_CS   | releasing CS
// S_END_BYTE | one trailing 0xFF byte with CS high, then done
module sd_block_writer #(
  parameter int CLK_DIV    = 2,
  parameter int BLOCK_LEN  = 512,
  parameter int R1_TRIES   = 8,
  parameter int BUSY_TRIES = 65535
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  sd_block_writer_if.slave io_sd
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_R1,
    S_GAP,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_RESP,
    S_BUSY,
    S_END_CS,
    S_END_BYTE
  } state_t;

  localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [15:0] R1_LAST    = 16'(R1_TRIES - 1);
  localparam logic [15:0] RESP_LAST  = 16'd7;
  localparam logic [15:0] BUSY_LAST  = 16'(BUSY_TRIES - 1);
  localparam logic [9:0]  DATA_LAST  = 10'(BLOCK_LEN - 1);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_idx;
  logic [15:0] r_try;
  logic [9:0]  r_data_cnt;
  logic [2:0]  r_error;
  logic        r_busy;
  logic        r_done;
  logic        r_pop;
  logic        r_cs;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_active;
  logic        r_byte_done;
  logic [2:0]  r_bit_cnt;
  logic [15:0] r_div_cnt;
  logic [7:0]  r_tx_sr;
  logic [7:0]  r_rx_sr;

  logic [7:0]  w_tx_byte;
  logic        w_launch;

  always_comb begin
    w_tx_byte = 8'hFF;
    case (r_state)
      S_CMD: begin
        case (r_idx)
          3'd0:    w_tx_byte = 8'h58;
          3'd1:    w_tx_byte = r_addr[31:24];
          3'd2:    w_tx_byte = r_addr[23:16];
          3'd3:    w_tx_byte = r_addr[15:8];
          3'd4:    w_tx_byte = r_addr[7:0];
          default: w_tx_byte = 8'hFF;
        endcase
      end
      S_TOKEN: w_tx_byte = 8'hFE;
      S_DATA:  w_tx_byte = io_sd.fifo_data;
      default: w_tx_byte = 8'hFF;
    endcase
  end

  // A new byte starts one clock after the previous one's done pulse, keeping SCLK low in the gap.
  always_comb begin
    w_launch = !r_active && !r_byte_done &&
               (r_state != S_IDLE) && (r_state != S_END_CS) &&
               !((r_state == S_DATA) && io_sd.fifo_empty);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= 32'h0;
      r_idx       <= 3'd0;
      r_try       <= 16'd0;
      r_data_cnt  <= 10'd0;
      r_error     <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pop       <= 1'b0;
      r_cs        <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b1;
      r_active    <= 1'b0;
      r_byte_done <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_div_cnt   <= 16'd0;
      r_tx_sr     <= 8'hFF;
      r_rx_sr     <= 8'hFF;
    end else begin
      r_byte_done <= 1'b0;
      r_done      <= 1'b0;
      r_pop       <= 1'b0;

      if (w_launch) begin
        r_active  <= 1'b1;
        r_tx_sr   <= w_tx_byte;
        r_mosi    <= w_tx_byte[7];
        r_bit_cnt <= 3'd0;
        r_div_cnt <= DIV_RELOAD;
      end else if (r_active) begin
        if (r_div_cnt != 16'd0) begin
          r_div_cnt <= r_div_cnt - 16'd1;
        end else begin
          r_div_cnt <= DIV_RELOAD;
          if (!r_sclk) begin
            r_sclk  <= 1'b1;
            r_rx_sr <= {r_rx_sr[6:0], io_sd.miso};
          end else begin
            r_sclk <= 1'b0;
            if (r_bit_cnt == 3'd7) begin
              r_active    <= 1'b0;
              r_byte_done <= 1'b1;
              r_mosi      <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx_sr   <= {r_tx_sr[6:0], 1'b1};
              r_mosi    <= r_tx_sr[6];
            end
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (io_sd.start) begin
            r_addr  <= io_sd.address;
            r_busy  <= 1'b1;
            r_error <= 3'd0;
            r_cs    <= 1'b0;
            r_idx   <= 3'd0;
            r_state <= S_CMD;
          end
        end
        S_CMD: begin
          if (r_byte_done) begin
            if (r_idx == 3'd5) begin
              r_idx   <= 3'd0;
              r_try   <= 16'd0;
              r_state <= S_R1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        S_R1: begin
          if (r_byte_done) begin
            if (r_rx_sr != 8'hFF) begin
              if (r_rx_sr == 8'h00) begin
                r_state <= S_GAP;
              end else begin
                r_error <= 3'd2;
                r_state <= S_END_CS;
              end
            end else if (r_try == R1_LAST) begin
              r_error <= 3'd1;
              r_state <= S_END_CS;
            end else begin
              r_try <= r_try + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (r_byte_done) r_state <= S_TOKEN;
        end
        S_TOKEN: begin
          if (r_byte_done) begin
            r_data_cnt <= 10'd0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_launch) r_pop <= 1'b1;
          if (r_byte_done) begin
            if (r_data_cnt == DATA_LAST) begin
              r_data_cnt <= 10'd0;
              r_idx      <= 3'd0;
              r_state    <= S_CRC;
            end else begin
              r_data_cnt <= r_data_cnt + 10'd1;
            end
          end
        end
        S_CRC: begin
          if (r_byte_done) begin
            if (r_idx == 3'd1) begin
              r_try   <= 16'd0;
              r_state <= S_RESP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        S_RESP: begin
          if (r_byte_done) begin
            if (r_rx_sr != 8'hFF) begin
              if (r_rx_sr[4:0] == 5'h05) begin
                r_try   <= 16'd0;
                r_state <= S_BUSY;
              end else begin
                r_error <= 3'd3;
                r_state <= S_END_CS;
              end
            end else if (r_try == RESP_LAST) begin
              r_error <= 3'd3;
              r_state <= S_END_CS;
            end else begin
              r_try <= r_try + 16'd1;
            end
          end
        end
        S_BUSY: begin
          if (r_byte_done) begin
            if (r_rx_sr != 8'h00) begin
              r_state <= S_END_CS;
            end else if (r_try == BUSY_LAST) begin
              r_error <= 3'd4;
              r_state <= S_END_CS;
            end else begin
              r_try <= r_try + 16'd1;
            end
          end
        end
        S_END_CS: begin
          r_cs    <= 1'b1;
          r_state <= S_END_BYTE;
        end
        S_END_BYTE: begin
          if (r_byte_done) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_sd.fifo_pop = r_pop;
  assign io_sd.mosi     = r_mosi;
  assign io_sd.sclk     = r_sclk;
  assign io_sd.cs       = r_cs;
  assign io_sd.busy     = r_busy;
  assign io_sd.done     = r_done;
  assign io_sd.error    = r_error;

endmodule
